// File: rtl/pipe_nbit_adder.sv
// rtl/pipe_nbit_adder.sv - Chunk-serial WIDTH-bit adder with valid/ready handshakes
//
// Adds a + b + cin over NCHUNK = WIDTH/CHUNK cycles, CHUNK bits per cycle,
// and reports sum, carry-out and signed overflow.
// Optional macro PIPE_NBIT_ADDER_SUB_EN adds a 'sub' input that selects a - b.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - operands present
//   in_ready   - block can accept operands (IDLE)
//   a, b       - WIDTH-bit operands
//   cin        - carry-in (ignored when sub=1)
//   sub        - (PIPE_NBIT_ADDER_SUB_EN only) 1 selects a - b
//   out_valid  - result present (DONE)
//   out_ready  - consumer accepts the result
//   sum        - WIDTH-bit result
//   cout       - carry out of the MSB (1 = no borrow when subtracting)
//   ovf        - two's-complement signed overflow
module pipe_nbit_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_NBIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("pipe_nbit_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [IDXW-1:0]  idx;

    logic             last_chunk;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             msb_cin;

    // Operand conditioning at capture: subtraction stores ~b and seeds carry=1
    logic [WIDTH-1:0] b_cap;
    logic             carry_cap;

`ifdef PIPE_NBIT_ADDER_SUB_EN
    assign b_cap     = sub ? ~b : b;
    assign carry_cap = sub ? 1'b1 : cin;
`else
    assign b_cap     = b;
    assign carry_cap = cin;
`endif

    assign last_chunk = (idx == IDXW'(NCHUNK - 1));

    // Select the current chunk by shifting it down to bit 0
    assign a_sh    = a_r >> (int'(idx) * CHUNK);
    assign b_sh    = b_r >> (int'(idx) * CHUNK);
    assign a_chunk = a_sh[CHUNK-1:0];
    assign b_chunk = b_sh[CHUNK-1:0];

    assign {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                   + {{CHUNK{1'b0}}, carry};

    // Carry into the top bit of this chunk, recovered from its sum bit
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b_cap;
                        carry  <= carry_cap;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                        idx    <= '0;
                    end
                end
                BUSY: begin
                    sum_r[int'(idx)*CHUNK +: CHUNK] <= chunk_sum;
                    carry <= chunk_cout;
                    if (last_chunk) begin
                        idx    <= '0;
                        cout_r <= chunk_cout;
                        ovf_r  <= msb_cin ^ chunk_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_pipe_nbit_adder.sv
// tb/tb_pipe_nbit_adder.sv - Scoreboard bench for pipe_nbit_adder
module tb_pipe_nbit_adder;

    parameter int WIDTH = 16;
    parameter int CHUNK = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

`ifdef PIPE_NBIT_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   checks;
    int   errors;
    int   cyc;
    bit   rand_ready;
    exp_t exp_q[$];

    pipe_nbit_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_NBIT_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operands
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t             e;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] nb;
        nb = ~mb;
        if (msub) full = {1'b0, ma} + {1'b0, nb} + 1;
        else      full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        if (msub) e.ovf = (ma[WIDTH-1] != mb[WIDTH-1]) && (e.sum[WIDTH-1] != ma[WIDTH-1]);
        else      e.ovf = (ma[WIDTH-1] == mb[WIDTH-1]) && (e.sum[WIDTH-1] != ma[WIDTH-1]);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per new result, checks stability while held
    logic             prev_valid;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    logic             held_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_result: got out_valid=1 sum=%0h expected no result (t=%0t)",
                             sum, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("latency", 32'(cyc - e.acc), 32'(NCHUNK));
                end
                held_sum  = sum;
                held_cout = cout;
                held_ovf  = ovf;
            end else if (out_valid) begin
                chk("held_sum", 32'(sum), 32'(held_sum));
                chk("held_cout", 32'(cout), 32'(held_cout));
                chk("held_ovf", 32'(ovf), 32'(held_ovf));
            end
            if (out_valid) chk("in_ready_in_done", 32'(in_ready), 32'd0);
            prev_valid = out_valid;
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tcin, input logic tsub);
        int   n;
        exp_t e;
        a        = ta;
        b        = tb_;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end else begin
            e     = model(ta, tb_, tcin, tsub);
            e.acc = cyc + 1;
            exp_q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain();
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        drain();
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drain();

        // Hold result in DONE with back-pressure; a second request is ignored
        out_ready = 1'b0;
        do_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("hold_reached_done", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 16'h0F0F;
        b        = 16'h0101;
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset in the second BUSY cycle abandons the operation
        do_op(16'h2222, 16'h3333, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (NCHUNK + 4) @(negedge clk);
        chk("abort_no_result", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        do_op(16'h0102, 16'h0304, 1'b1, 1'b0);
        drain();

        if (SUB_EN) begin
            do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
            drain();
            do_op(16'h8000, 16'h0001, 1'b0, 1'b1);
            drain();
        end

        // Randomized operations with random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic rs;
            rs = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), rs);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_nbit_adder.md
PIPE_NBIT_ADDER -- requirements
Module: pipe_nbit_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operands present.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port sum, output, WIDTH: result.
REQ-013 SHALL have port cout, output, 1: carry-out of MSB.
REQ-014 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-015 SHALL enforce WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH, with an elaboration-time error otherwise.
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge captures a, b, cin, clears chunk index, sets carry register=cin, goes to BUSY.
REQ-018 BUSY: in_ready=0; each cycle adds chunk idx of A and B plus carry register, writes CHUNK sum bits at idx, updates carry, increments idx.
REQ-019 BUSY with idx==NCHUNK-1: after that edge, SHALL go to DONE with cout = final carry and ovf = carry into MSB XOR carry out of MSB.
REQ-020 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accepting edge; CHUNK==WIDTH gives 1 cycle.
REQ-021 DONE: out_valid=1, in_ready=0; sum, cout, ovf held stable until out_ready=1 at an edge, then IDLE.
REQ-022 in_valid while BUSY or DONE SHALL be ignored, with no capture and no state change.
REQ-023 Throughput: one operation per NCHUNK+2 cycles minimum; no overlap of operations.
REQ-024 sum/cout/ovf SHALL be valid only while out_valid=1; partial values are visible during BUSY.
REQ-025 Result SHALL equal (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
REQ-027 Reset during BUSY or DONE SHALL abandon the operation, with no result emitted after release.
REQ-028 First capture after reset SHALL occur at the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-029 Macro PIPE_NBIT_ADDER_SUB_EN, when defined, SHALL add input port sub (1 bit), captured with the operands.
REQ-030 With the macro defined and sub=1, the block SHALL compute a + ~b + 1 (a − b), ignoring cin; cout=1 means no borrow; ovf is signed subtraction overflow.
REQ-031 With the macro defined and sub=0, and with the macro undefined, behaviour SHALL be identical to the add-only behaviour in REQ-017..REQ-025.
REQ-032 Without the macro, port sub SHALL not exist.

Verification (WIDTH=16, CHUNK=4)
REQ-033 Bench SHALL cover: a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> out_valid 4 cycles after accept, sum=0x0000, cout=1, ovf=0.
REQ-034 Bench SHALL cover: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
REQ-035 Bench SHALL cover: out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Bench SHALL cover: rst_n asserted at 2nd BUSY cycle -> outputs zero immediately, no out_valid after release, next op correct.
REQ-037 Bench SHALL cover, with PIPE_NBIT_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
REQ-038 Bench SHALL cover: CHUNK=16 build, a=0x00FF, b=0x0001 -> sum=0x0100, latency 1 cycle.
